// File: rtl/rob_commit.sv
// In-order retirement buffer: allocates entries at dispatch, records FU results,
// retires the head entry onto a registered commit port, and serves two forwarding reads.
module rob_commit #(
  parameter int ROB_DEPTH     = 32,
  parameter int ROB_IDX_WIDTH = $clog2(ROB_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  // Dispatch allocation
  input  logic                     alloc_valid,
  input  logic [4:0]               alloc_rd_addr,
  input  logic [31:0]              alloc_pc,
  output logic                     alloc_ready,
  output logic [ROB_IDX_WIDTH-1:0] alloc_rob_idx,
  // FU writeback
  input  logic                     wb_valid,
  input  logic [ROB_IDX_WIDTH-1:0] wb_rob_idx,
  input  logic [31:0]              wb_data,
  // Forwarding read ports
  input  logic [ROB_IDX_WIDTH-1:0] rd_idx_a,
  input  logic [ROB_IDX_WIDTH-1:0] rd_idx_b,
  output logic                     rd_done_a,
  output logic                     rd_done_b,
  output logic [31:0]              rd_data_a,
  output logic [31:0]              rd_data_b,
  // Commit port
  output logic                     commit_valid,
  output logic                     commit_regf_we,
  output logic [4:0]               commit_rd_addr,
  output logic [31:0]              commit_data,
  output logic [ROB_IDX_WIDTH-1:0] commit_rob_idx,
  output logic [31:0]              commit_pc,
  // Occupancy
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = ROB_IDX_WIDTH + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;

  logic [ROB_DEPTH-1:0] valid_q, valid_d;
  logic [ROB_DEPTH-1:0] done_q,  done_d;
  entry_t [ROB_DEPTH-1:0] entry_q, entry_d;

  logic                     commit_valid_q,   commit_valid_d;
  logic                     commit_regf_we_q, commit_regf_we_d;
  logic [4:0]               commit_rd_addr_q, commit_rd_addr_d;
  logic [31:0]              commit_data_q,    commit_data_d;
  logic [ROB_IDX_WIDTH-1:0] commit_rob_idx_q, commit_rob_idx_d;
  logic [31:0]              commit_pc_q,      commit_pc_d;

  logic [ROB_IDX_WIDTH-1:0] head_idx;
  logic [ROB_IDX_WIDTH-1:0] tail_idx;
  logic                     full_w;
  logic                     do_alloc;
  logic                     do_wb;
  logic                     do_retire;

  assign head_idx = head_q[ROB_IDX_WIDTH-1:0];
  assign tail_idx = tail_q[ROB_IDX_WIDTH-1:0];

  assign full_w = (head_idx == tail_idx) && (head_q[PTR_W-1] != tail_q[PTR_W-1]);

  assign empty         = (head_q == tail_q);
  assign full          = full_w;
  assign alloc_ready   = !full_w;
  assign alloc_rob_idx = tail_idx;

  // All three decisions look only at registered state, so a same-cycle
  // writeback to head cannot retire until the following cycle.
  assign do_alloc  = alloc_valid && !full_w;
  assign do_wb     = wb_valid && valid_q[wb_rob_idx];
  assign do_retire = valid_q[head_idx] && done_q[head_idx];

  assign rd_done_a = valid_q[rd_idx_a] && done_q[rd_idx_a];
  assign rd_done_b = valid_q[rd_idx_b] && done_q[rd_idx_b];
  assign rd_data_a = entry_q[rd_idx_a].data;
  assign rd_data_b = entry_q[rd_idx_b].data;

  // NOTE: every always_comb target gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    head_d           = head_q;
    tail_d           = tail_q;
    valid_d          = valid_q;
    done_d           = done_q;
    entry_d          = entry_q;
    commit_valid_d   = 1'b0;
    commit_regf_we_d = 1'b0;
    commit_rd_addr_d = commit_rd_addr_q;
    commit_data_d    = commit_data_q;
    commit_rob_idx_d = commit_rob_idx_q;
    commit_pc_d      = commit_pc_q;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      valid_d = '0;
      done_d  = '0;
    end else begin
      if (do_wb) begin
        done_d[wb_rob_idx]       = 1'b1;
        entry_d[wb_rob_idx].data = wb_data;
      end

      if (do_retire) begin
        valid_d[head_idx] = 1'b0;
        head_d            = head_q + PTR_ONE;
        commit_valid_d    = 1'b1;
        commit_regf_we_d  = (entry_q[head_idx].rd != 5'd0);
        commit_rd_addr_d  = entry_q[head_idx].rd;
        commit_data_d     = entry_q[head_idx].data;
        commit_rob_idx_d  = head_idx;
        commit_pc_d       = entry_q[head_idx].pc;
      end

      // Alloc never targets the retiring slot: it is refused when full, and
      // when empty the head entry is not valid so nothing retires.
      if (do_alloc) begin
        valid_d[tail_idx]    = 1'b1;
        done_d[tail_idx]     = 1'b0;
        entry_d[tail_idx].rd = alloc_rd_addr;
        entry_d[tail_idx].pc = alloc_pc;
      end
      if (do_alloc) begin
        tail_d = tail_q + PTR_ONE;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q           <= '0;
      tail_q           <= '0;
      valid_q          <= '0;
      done_q           <= '0;
      commit_valid_q   <= 1'b0;
      commit_regf_we_q <= 1'b0;
      commit_rd_addr_q <= '0;
      commit_data_q    <= '0;
      commit_rob_idx_q <= '0;
      commit_pc_q      <= '0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      valid_q          <= valid_d;
      done_q           <= done_d;
      commit_valid_q   <= commit_valid_d;
      commit_regf_we_q <= commit_regf_we_d;
      commit_rd_addr_q <= commit_rd_addr_d;
      commit_data_q    <= commit_data_d;
      commit_rob_idx_q <= commit_rob_idx_d;
      commit_pc_q      <= commit_pc_d;
    end
  end

  // NOTE: the payload array is deliberately not reset; valid/done gate every
  // use of it, and leaving it out of reset keeps it a plain register file.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  assign commit_valid   = commit_valid_q;
  assign commit_regf_we = commit_regf_we_q;
  assign commit_rd_addr = commit_rd_addr_q;
  assign commit_data    = commit_data_q;
  assign commit_rob_idx = commit_rob_idx_q;
  assign commit_pc      = commit_pc_q;

endmodule
